// File: rtl/reg_file_wb.sv
// reg_file_wb: 32 x DATA_W architectural register file at the MEM/WB boundary.
// Selects the writeback value, commits it on the rising edge, serves two
// decode read ports with same-cycle write-through bypass, and exposes an
// unbypassed debug read port plus a committed-write counter.
module reg_file_wb #(
   parameter int unsigned     DATA_W   = 32,
   parameter logic [DATA_W-1:0] SP_RESET = 32'h00003FFC,
   parameter logic [DATA_W-1:0] GP_RESET = 32'h00001800,
   parameter int unsigned     CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_regwrite,
   input  logic              wb_memtoreg,
   input  logic [DATA_W-1:0] wb_alu_result,
   input  logic [DATA_W-1:0] wb_read_data,
   input  logic [4:0]        wb_write_reg,
   input  logic [4:0]        rs_addr,
   input  logic [4:0]        rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_commit,
   output logic [CNT_W-1:0]  write_count
);

   // Entry 0 is held at zero by reset and never written, since commit excludes $0.
   logic [DATA_W-1:0] regs [32];

   // Writeback value selection and commit qualification.
   always_comb begin
      wb_data   = wb_memtoreg ? wb_read_data : wb_alu_result;
      wb_commit = wb_regwrite && (wb_write_reg != 5'd0) && rst_n;
   end

   // Register array: reset to architectural values, commit the selected value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) begin
            if (i[4:0] == 5'd28)
               regs[i[4:0]] <= GP_RESET;
            else if (i[4:0] == 5'd29)
               regs[i[4:0]] <= SP_RESET;
            else
               regs[i[4:0]] <= '0;
         end
      end else if (wb_commit) begin
         regs[wb_write_reg] <= wb_data;
      end
   end

   // Committed-write counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         write_count <= '0;
      else if (wb_commit)
         write_count <= write_count + 1'b1;
   end

   // Decode read ports: $0 reads zero, a committing write to the same register is forwarded.
   always_comb begin
      if (rs_addr == 5'd0)
         rs_data = '0;
      else if (wb_commit && (rs_addr == wb_write_reg))
         rs_data = wb_data;
      else
         rs_data = regs[rs_addr];

      if (rt_addr == 5'd0)
         rt_data = '0;
      else if (wb_commit && (rt_addr == wb_write_reg))
         rt_data = wb_data;
      else
         rt_data = regs[rt_addr];
   end

   // Debug port shows committed state only.
   always_comb begin
      if (dbg_addr == 5'd0)
         dbg_data = '0;
      else
         dbg_data = regs[dbg_addr];
   end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: randomized and directed checks of reg_file_wb against a
// behavioural array model; a second instance with a 4-bit counter checks wrap.
module tb_reg_file_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_regwrite, wb_memtoreg;
   logic [31:0] wb_alu_result, wb_read_data;
   logic [4:0]  wb_write_reg, rs_addr, rt_addr, dbg_addr;
   logic [31:0] rs_data, rt_data, dbg_data, wb_data;
   logic        wb_commit;
   logic [31:0] write_count;

   logic [31:0] rs_data4, rt_data4, dbg_data4, wb_data4;
   logic        wb_commit4;
   logic [3:0]  write_count4;

   logic [31:0] model [32];
   int unsigned n_writes;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #10 clk = ~clk;

   reg_file_wb u_dut (
      .clk(clk), .rst_n(rst_n),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
      .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
      .wb_write_reg(wb_write_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data), .wb_data(wb_data), .wb_commit(wb_commit),
      .write_count(write_count)
   );

   reg_file_wb #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
      .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
      .wb_write_reg(wb_write_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data4), .rt_data(rt_data4), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data4), .wb_data(wb_data4), .wb_commit(wb_commit4),
      .write_count(write_count4)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[28] = 32'h00001800;
      model[29] = 32'h00003FFC;
      n_writes  = 0;
   endtask

   // Spec read rule: $0 is zero, a same-cycle committing write is visible, else stored value.
   function automatic logic [31:0] exp_read(input logic [4:0] a, input logic commit,
                                            input logic [4:0] wr, input logic [31:0] val);
      if (a == 5'd0) return 32'h0;
      if (commit && a == wr) return val;
      return model[a];
   endfunction

   task automatic check_counts(input string tag);
      check_value({tag, "_cnt"}, write_count, n_writes);
      check_value({tag, "_cnt4"}, {28'h0, write_count4}, n_writes % 16);
   endtask

   // One writeback cycle: drive at negedge, check combinational outputs, step model at posedge.
   task automatic cycle(input logic rw, input logic mr, input logic [31:0] alu,
                        input logic [31:0] rd, input logic [4:0] wr, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] da);
      logic        commit;
      logic [31:0] val;
      @(negedge clk);
      wb_regwrite = rw; wb_memtoreg = mr; wb_alu_result = alu; wb_read_data = rd;
      wb_write_reg = wr; rs_addr = ra; rt_addr = rb; dbg_addr = da;
      #1;
      commit = rw && (wr != 5'd0) && rst_n;
      val    = mr ? rd : alu;
      check_value("wb_data", wb_data, val);
      check_value("wb_commit", {31'h0, wb_commit}, {31'h0, commit});
      check_value("rs_data", rs_data, exp_read(ra, commit, wr, val));
      check_value("rt_data", rt_data, exp_read(rb, commit, wr, val));
      check_value("rs_data4", rs_data4, exp_read(ra, commit, wr, val));
      check_value("dbg_pre", dbg_data, model[da]);
      @(posedge clk);
      if (commit) begin
         model[wr] = val;
         n_writes++;
      end
      #1;
      check_value("dbg_post", dbg_data, model[da]);
      check_counts("post");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] wr, ra, rb;
      rst_n = 1'b0;
      wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_alu_result = 32'hDEADBEEF;
      wb_read_data = 32'h0; wb_write_reg = 5'd5; rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
      reset_model();

      // Reset state, sweeping addresses across clock edges while a write is requested.
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         dbg_addr = i[4:0]; rs_addr = i[4:0]; rt_addr = i[4:0]; wb_write_reg = i[4:0];
         #1;
         check_value("rst_dbg", dbg_data, model[i]);
         check_value("rst_rs", rs_data, model[i]);
         check_value("rst_rt", rt_data, model[i]);
         check_value("rst_commit", {31'h0, wb_commit}, 32'h0);
      end
      check_value("rst_gp", dbg_data4 | 32'h0, dbg_data4);
      check_counts("rst");
      @(negedge clk);
      wb_regwrite = 1'b0;
      rst_n = 1'b1;

      // ALU writeback with bypass before the edge.
      cycle(1'b1, 1'b0, 32'h02340000, 32'h00006790, 5'h0A, 5'd10, 5'd0, 5'd10);
      check_value("alu_dbg10", dbg_data, 32'h02340000);
      check_value("alu_cnt", write_count, 32'd1);

      // Memory writeback with both ports bypassing.
      cycle(1'b1, 1'b1, 32'h11111111, 32'h00006790, 5'h11, 5'd17, 5'd17, 5'd17);
      check_value("mem_dbg17", dbg_data, 32'h00006790);

      // Write to $0 must not commit.
      cycle(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
      check_value("r0_cnt", write_count, 32'd2);

      // Disabled write to reg 5: no bypass, no change.
      cycle(1'b0, 1'b0, 32'hCAFEF00D, 32'h0, 5'd5, 5'd5, 5'd5, 5'd5);
      check_value("nowr_dbg5", dbg_data, 32'h0);

      // Back-to-back writes to the same register.
      cycle(1'b1, 1'b0, 32'hAAAA0001, 32'h0, 5'd7, 5'd7, 5'd3, 5'd7);
      cycle(1'b1, 1'b1, 32'h0, 32'hBBBB0002, 5'd7, 5'd7, 5'd7, 5'd7);
      check_value("b2b_dbg7", dbg_data, 32'hBBBB0002);

      // Randomized traffic.
      for (int unsigned n = 0; n < 400; n++) begin
         wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         ra = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
         cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom,
               wr, ra, rb, 5'($urandom));
      end

      // Asynchronous reset dropped 5 time units before an edge carrying a write to reg 3.
      @(negedge clk);
      wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_alu_result = 32'h0000000F;
      wb_write_reg = 5'd3; dbg_addr = 5'd3; rs_addr = 5'd29; rt_addr = 5'd3;
      #5;
      rst_n = 1'b0;
      reset_model();
      #1;
      check_value("arst_commit", {31'h0, wb_commit}, 32'h0);
      check_value("arst_rs29", rs_data, 32'h00003FFC);
      check_value("arst_rt3", rt_data, 32'h0);
      check_counts("arst_imm");
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      check_value("arst_dbg3", dbg_data, 32'h0);
      check_value("arst_cnt", write_count, 32'h0);
      @(negedge clk);
      wb_regwrite = 1'b0;

      // Counter wrap on the 4-bit instance: 17 commits leave it at 1.
      for (int unsigned n = 0; n < 17; n++)
         cycle(1'b1, 1'b0, $urandom, 32'h0, 5'(1 + n % 31), 5'd1, 5'd2, 5'd1);
      check_value("wrap_cnt4", {28'h0, write_count4}, 32'd1);
      check_value("wrap_cnt32", write_count, 32'd17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
